adc_sample_scheduler: RTL
=========================

Name: adc_sample_scheduler

Overview:
- Sequences the ADS8528 parallel-mode driver at a programmable sample rate.
- Issues one conversion-start pulse per frame, supervises the ADC Busy response and collects the per-channel words the driver emits on toMem/mem_ready.
- Forwards the words, tagged with channel index, frame number and last-flag, through a small FIFO to the downstream memory writer over a valid/ready stream.
- Reports overrun, timeout and dropped-word errors.

Parameters:
- NUM_CH, 8, maximum channel words per frame
- DATA_W, 16, sample width
- DIV_W, 16, width of the period register
- TIMEOUT_CYC, 256, maximum cycles allowed for a Busy response or between consecutive words
- FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run frames while high
- period  in  DIV_W  frame period minus 1, in clk cycles
- n_ch  in  4  channel words per frame; 0 or values above NUM_CH are treated as NUM_CH
- conv_start  out  1  one-cycle conversion trigger to the driver
- adc_busy  in  1  ADC Busy line
- word_valid  in  1  driver mem_ready pulse
- word_data  in  DATA_W  driver toMem word
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  sample
- m_chan  out  3  channel index, 0..n_ch-1
- m_last  out  1  final word of the frame
- m_frame  out  8  frame number, wraps 255 to 0
- active  out  1  high in any state other than IDLE
- clr_err  in  1  clears the error flags and drop_cnt
- overrun  out  1  sticky: a frame tick arrived while the previous frame was unfinished
- timeout_err  out  1  sticky: a frame was aborted on timeout
- drop_cnt  out  8  saturating count of words not accepted

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, frame counter 0, period counter 0. Reset mid-frame aborts immediately; the FIFO contents are discarded.
- Effective period: period_eff = max(period, 2*NUM_CH+4).
- Tick generation:
  - While enable=0, the counter is held at 0.
  - While enable=1: tick when the counter is 0, then reload period_eff; otherwise decrement.
  - The first tick occurs on the first enabled cycle; subsequent ticks every period_eff+1 cycles.
- State machine states: IDLE, TRIGGER, WAIT_BUSY, COLLECT.
- IDLE:
  - A tick moves the block to TRIGGER.
  - On that transition the block latches n_ch_eff and the current frame number.
- TRIGGER:
  - conv_start=1 for exactly this one cycle.
  - Clears the timeout counter, then moves to WAIT_BUSY.
  - conv_start therefore rises the cycle after the tick.
- WAIT_BUSY:
  - adc_busy=1 moves the block to COLLECT and clears the timeout counter.
  - A word_valid arriving in this state is discarded and increments drop_cnt.
- COLLECT:
  - Each word_valid pushes {word_data, idx, idx==n_ch_eff-1, frame} and increments idx; the timeout counter clears on every word.
  - After the push with last=1: the frame number increments, idx clears and the state returns to IDLE.
- Timeout:
  - In WAIT_BUSY or COLLECT, if the timeout counter reaches TIMEOUT_CYC, set timeout_err and return to IDLE.
  - The frame number still increments; words already pushed remain in the FIFO, and no m_last is emitted for that frame.
- Tick while not IDLE: set overrun and skip the tick. The counter reloads as normal and the frame number does not advance.
- word_valid in IDLE: discarded and counted in drop_cnt.
- FIFO push/pop:
  - A push is accepted if the FIFO is not full, or if it is full and m_ready&&m_valid in the same cycle.
  - Otherwise the word is dropped and drop_cnt increments; the frame index still advances.
- Output timing:
  - Latency from word_valid to m_valid is 1 cycle when the FIFO is empty.
  - m_* outputs are stable while m_valid && !m_ready.
- Error flags:
  - clr_err clears overrun, timeout_err and drop_cnt.
  - If a set event occurs in the same cycle as clr_err, the set wins (a drop leaves drop_cnt=1).
  - drop_cnt saturates at 255.
- Enable and parameter changes:
  - Deasserting enable mid-frame lets the current frame complete normally; no further ticks occur.
  - period and n_ch changes take effect only at the next frame latch or counter reload.

Decomposition:
- Shared package adc_sched_pkg:
  - sched_state_t enum.
  - sample_t packed struct {data, chan, last, frame}.
  - MIN_PERIOD function.
  - Timeout and NUM_CH default constants.
- One sub-module, adc_sample_fifo: synchronous FIFO of sample_t, FIFO_DEPTH entries, full/empty flags, with the full-but-popping push rule above.

Test Plan:
- enable=1, period=99, n_ch=4; driver model raises busy 2 cycles after conv_start and emits 4 words (0x1000..0x1003) -> conv_start every 100 cycles; m_chan 0..3; m_last only on 0x1003; m_frame 0,1,2.
- period=3 -> conv_start spacing is 21 cycles (period_eff=20).
- Driver model takes 150 cycles per frame with period=99 -> overrun=1 on the second tick; m_frame sequence has no gaps; clr_err clears overrun.
- adc_busy held 0 -> after TIMEOUT_CYC cycles timeout_err=1, state IDLE, no m_valid; the next tick restarts normally.
- m_ready=0 with n_ch=8 -> first 4 words stored, drop_cnt=4; after m_ready=1 the stored words drain in order with m_chan 0..3.
- Assert rst mid-COLLECT -> next cycle all outputs 0, FIFO empty, m_frame 0; word_valid in IDLE increments drop_cnt to 1.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
package adc_sched_pkg;

  localparam int NUM_CH_DEF      = 8;
  localparam int DATA_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 256;
  localparam int CHAN_W          = 3;
  localparam int FRAME_W         = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRIGGER   = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_COLLECT   = 2'd3
  } sched_state_t;

  // One forwarded sample: the ADC word plus its position in the frame.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [CHAN_W-1:0]     chan;
    logic                  last;
    logic [FRAME_W-1:0]    frame;
  } sample_t;

  // Shortest usable frame period (minus 1): a full frame of words
  // collected back-to-back plus trigger/busy overhead.
  function automatic int MIN_PERIOD(input int num_ch);
    return 2 * num_ch + 4;
  endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Output sample stream from the scheduler to the memory writer.
//
// Handshake: a sample transfers on a rising clk edge where m_valid and
// m_ready are both high. m_valid never waits for m_ready, and once m_valid
// is high the payload (m_data, m_chan, m_last, m_frame) holds steady until
// the transfer happens.
interface adc_sample_scheduler_if #(
  parameter int DATA_W = 16
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_chan;
  logic              m_last;
  logic [7:0]        m_frame;

  modport master (
    output m_valid, m_data, m_chan, m_last, m_frame,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_chan, m_last, m_frame,
    output m_ready
  );
endinterface

// File: rtl/adc_sample_fifo.sv
// Small synchronous FIFO of sample_t. A push into a full FIFO still
// succeeds when the head is being popped in the same cycle.
module adc_sample_fifo
  import adc_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  sample_t push_data,
  input  logic    pop_ready,
  output sample_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  sample_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          pop;
  logic          accept;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = pop_ready && !empty;
  assign accept  = push && (!full || pop);
  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Frame sequencer for the ADS8528 parallel-mode driver: periodic
// conversion trigger, Busy supervision, word collection and tagging,
// output FIFO and sticky error reporting.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DIV_W       = 16,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       period,
  input  logic [3:0]             n_ch,
  output logic                   conv_start,
  input  logic                   adc_busy,
  input  logic                   word_valid,
  input  logic [DATA_W-1:0]      word_data,
  adc_sample_scheduler_if.master m_if,
  output logic                   active,
  input  logic                   clr_err,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic [7:0]             drop_cnt,
  output sched_state_t           dbg_state
);

  localparam logic [DIV_W-1:0] PERIOD_MIN = DIV_W'(MIN_PERIOD(NUM_CH));
  localparam int               TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYC);
  localparam logic [3:0]       NUM_CH_L   = 4'(NUM_CH);

  sched_state_t      state, state_d;
  logic [DIV_W-1:0]  tick_cnt;
  logic [DIV_W-1:0]  period_eff;
  logic              tick;
  logic [3:0]        n_ch_eff;
  logic [3:0]        n_ch_lat;
  logic [2:0]        idx;
  logic [7:0]        frame;
  logic [TO_W-1:0]   to_cnt;
  logic              is_last;

  logic              latch, push, frame_inc, to_clr, to_inc;
  logic              drop_in, timeout_set, overrun_set, drop_evt, push_drop;

  sample_t           push_data, head;
  logic              fifo_full, fifo_empty;

  assign period_eff = (period < PERIOD_MIN) ? PERIOD_MIN : period;
  assign n_ch_eff   = (n_ch == 4'd0 || n_ch > NUM_CH_L) ? NUM_CH_L : n_ch;
  assign tick       = enable && (tick_cnt == '0);
  assign is_last    = ({1'b0, idx} == (n_ch_lat - 4'd1));

  // Frame tick counter: held at 0 while disabled, so the first enabled
  // cycle ticks; afterwards reloads period_eff on every tick.
  always_ff @(posedge clk) begin
    if (rst || !enable)       tick_cnt <= '0;
    else if (tick_cnt == '0)  tick_cnt <= period_eff;
    else                      tick_cnt <= tick_cnt - DIV_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d     = state;
    conv_start  = 1'b0;
    latch       = 1'b0;
    push        = 1'b0;
    frame_inc   = 1'b0;
    to_clr      = 1'b0;
    to_inc      = 1'b0;
    drop_in     = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        drop_in = word_valid;
        if (tick) begin
          state_d = S_TRIGGER;
          latch   = 1'b1;
        end
      end
      S_TRIGGER: begin
        conv_start = 1'b1;
        to_clr     = 1'b1;
        drop_in    = word_valid;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        drop_in = word_valid;
        if (adc_busy) begin
          state_d = S_COLLECT;
          to_clr  = 1'b1;
        end else if (to_cnt == TO_LIMIT) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
          frame_inc   = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_COLLECT: begin
        if (word_valid) begin
          push   = 1'b1;
          to_clr = 1'b1;
          if (is_last) begin
            state_d   = S_IDLE;
            frame_inc = 1'b1;
          end
        end else if (to_cnt == TO_LIMIT) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
          frame_inc   = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame context: channel count latched at frame start, word index and
  // frame number (which advances on completion or abort).
  always_ff @(posedge clk) begin
    if (rst) begin
      n_ch_lat <= '0;
      idx      <= '0;
      frame    <= '0;
    end else begin
      if (latch) n_ch_lat <= n_ch_eff;
      if (latch || frame_inc) idx <= '0;
      else if (push)          idx <= idx + 3'd1;
      if (frame_inc) frame <= frame + 8'd1;
    end
  end

  // Watchdog counter for the Busy response and inter-word gaps.
  always_ff @(posedge clk) begin
    if (rst || to_clr) to_cnt <= '0;
    else if (to_inc)   to_cnt <= to_cnt + TO_W'(1);
  end

  assign overrun_set = tick && (state != S_IDLE);
  assign push_drop   = push && fifo_full && !(m_if.m_valid && m_if.m_ready);
  assign drop_evt    = drop_in || push_drop;

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      drop_cnt    <= '0;
    end else if (clr_err) begin
      overrun     <= overrun_set;
      timeout_err <= timeout_set;
      drop_cnt    <= drop_evt ? 8'd1 : 8'd0;
    end else begin
      if (overrun_set) overrun     <= 1'b1;
      if (timeout_set) timeout_err <= 1'b1;
      if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign push_data.data  = word_data;
  assign push_data.chan  = idx;
  assign push_data.last  = is_last;
  assign push_data.frame = frame;

  adc_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop_ready (m_if.m_ready),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = head.data;
  assign m_if.m_chan  = head.chan;
  assign m_if.m_last  = head.last;
  assign m_if.m_frame = head.frame;

  assign active    = (state != S_IDLE);
  assign dbg_state = state;

endmodule
